// File: rtl/axi_lite_uart_regs.sv
// AXI4-Lite register front end for the UART: RX/TX byte FIFOs, status,
// control and a single-cycle interrupt pulse.
module axi_lite_uart_regs #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic [3:0]           s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [3:0]           s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_strobe,
    input  logic                 rx_frame_err,
    input  logic                 rx_parity_err,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg, tx_wr_ptr_reg, tx_rd_ptr_reg;

    logic        intr_en_reg, interrupt_reg, rx_empty_d_reg, tx_empty_d_reg;
    logic [2:0]  err_reg;           // [0] overrun, [1] frame, [2] parity
    logic [2:0]  err_set;
    logic [31:0] rdata_reg, rdata_next;
    logic [7:0]  stat_val;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic w_fire, r_fire, wr_en0, tx_wr, ctrl_wr, flush_tx, flush_rx;
    logic rx_push, rx_pop, tx_push, tx_pop, stat_rd;
    logic unused_ok;

    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1], s_axi_wdata};

    // Write channel state register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) w_state_reg <= W_IDLE;
        else                w_state_reg <= w_state_next;
    end

    // Write channel next state: address and data must both be present to accept
    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (s_axi_awvalid && s_axi_wvalid) w_state_next = W_ACK;
            W_ACK:   w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel outputs decoded from state
    always_comb begin
        s_axi_awready = (w_state_reg == W_ACK);
        s_axi_wready  = (w_state_reg == W_ACK);
        s_axi_bvalid  = (w_state_reg == W_RESP);
    end

    // Read channel state register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_state_reg <= R_IDLE;
        else                r_state_reg <= r_state_next;
    end

    // Read channel next state
    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (s_axi_arvalid) r_state_next = R_ACK;
            R_ACK:   r_state_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read channel outputs decoded from state
    always_comb begin
        s_axi_arready = (r_state_reg == R_ACK);
        s_axi_rvalid  = (r_state_reg == R_DATA);
    end

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign s_axi_rdata = rdata_reg;

    // Register side effects happen on the edge that ends the ACK cycle
    assign w_fire   = (w_state_reg == W_ACK);
    assign r_fire   = (r_state_reg == R_ACK);
    assign wr_en0   = w_fire && s_axi_wstrb[0];
    assign tx_wr    = wr_en0 && (s_axi_awaddr[3:2] == 2'd1);
    assign ctrl_wr  = wr_en0 && (s_axi_awaddr[3:2] == 2'd3);
    assign flush_tx = ctrl_wr && s_axi_wdata[0];
    assign flush_rx = ctrl_wr && s_axi_wdata[1];

    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[AW] != rx_rd_ptr_reg[AW]) &&
                      (rx_wr_ptr_reg[AW-1:0] == rx_rd_ptr_reg[AW-1:0]);
    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                      (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);

    assign rx_pop  = r_fire && (s_axi_araddr[3:2] == 2'd0) && !rx_empty;
    assign stat_rd = r_fire && (s_axi_araddr[3:2] == 2'd2);
    assign rx_push = rx_strobe && (!rx_full || rx_pop);
    assign tx_pop  = !tx_empty && tx_ready;
    assign tx_push = tx_wr && (!tx_full || tx_pop);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr_reg[AW-1:0]];

    assign stat_val = {err_reg[2], err_reg[1], err_reg[0], intr_en_reg,
                       tx_full, tx_empty, rx_full, !rx_empty};

    // FIFO storage writes; contents need no reset since pointers define validity
    always_ff @(posedge s_axi_aclk) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= s_axi_wdata[DATA_BITS-1:0];
    end

    // FIFO pointers; a flush overrides any same-cycle push or pop
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (flush_rx) begin
                rx_wr_ptr_reg <= '0;
                rx_rd_ptr_reg <= '0;
            end else begin
                if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
                if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
            end
            if (flush_tx) begin
                tx_wr_ptr_reg <= '0;
                tx_rd_ptr_reg <= '0;
            end else begin
                if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
                if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Read data selection; empty RX or write-only registers return zero
    always_comb begin
        rdata_next = '0;
        case (s_axi_araddr[3:2])
            2'd0:    if (!rx_empty) rdata_next[DATA_BITS-1:0] = rx_mem[rx_rd_ptr_reg[AW-1:0]];
            2'd2:    rdata_next[7:0] = stat_val;
            default: rdata_next = '0;
        endcase
    end

    // Read data register, held stable through the data phase
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) rdata_reg <= '0;
        else if (r_fire)    rdata_reg <= rdata_next;
    end

    assign err_set[0] = rx_strobe && rx_full && !rx_pop;
    assign err_set[1] = rx_strobe && rx_frame_err;
    assign err_set[2] = rx_strobe && rx_parity_err;

    // Sticky error flags: a new event in the clearing cycle is kept
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_err
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn)   err_reg[gi] <= 1'b0;
                else if (err_set[gi]) err_reg[gi] <= 1'b1;
                else if (stat_rd)     err_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    // Control enable and interrupt edge detection on FIFO emptiness
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            intr_en_reg    <= 1'b0;
            interrupt_reg  <= 1'b0;
            rx_empty_d_reg <= 1'b1;
            tx_empty_d_reg <= 1'b1;
        end else begin
            if (ctrl_wr) intr_en_reg <= s_axi_wdata[4];
            rx_empty_d_reg <= rx_empty;
            tx_empty_d_reg <= tx_empty;
            interrupt_reg  <= intr_en_reg &&
                              ((rx_empty_d_reg && !rx_empty) || (!tx_empty_d_reg && tx_empty));
        end
    end

    assign interrupt = interrupt_reg;

endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Directed/randomized bench for axi_lite_uart_regs with a queue-based model.
module tb_axi_lite_uart_regs;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr, araddr, wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic [7:0]  rx_data, tx_data;
    logic        rx_strobe, rx_frame_err, rx_parity_err, tx_valid, tx_ready, interrupt;

    int checks = 0;
    int errors = 0;
    int irq_count = 0;
    int exp_irq = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic m_en, m_ovr, m_frm, m_par;

    always #5 clk = ~clk;

    axi_lite_uart_regs #(.FIFO_DEPTH(16), .DATA_BITS(8)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .interrupt(interrupt)
    );

    // Count interrupt pulses away from the active edge
    always @(negedge clk) if (interrupt === 1'b1) irq_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_stat();
        return {m_par, m_frm, m_ovr, m_en, (tx_q.size() == 16), (tx_q.size() == 0),
                (rx_q.size() == 16), (rx_q.size() != 0)};
    endfunction

    task automatic model_reset();
        rx_q.delete(); tx_q.delete();
        m_en = 0; m_ovr = 0; m_frm = 0; m_par = 0;
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (strb[0]) begin
            if (addr[3:2] == 2'd1) begin
                if (tx_q.size() < 16) tx_q.push_back(data[7:0]);
            end else if (addr[3:2] == 2'd3) begin
                m_en = data[4];
                if (data[0]) begin
                    if (tx_q.size() > 0 && m_en) exp_irq++;
                    tx_q.delete();
                end
                if (data[1]) rx_q.delete();
            end
        end
    endtask

    task automatic model_read(input logic [3:0] addr, output logic [31:0] e);
        e = 32'h0;
        if (addr[3:2] == 2'd0) begin
            if (rx_q.size() > 0) e = {24'h0, rx_q.pop_front()};
        end else if (addr[3:2] == 2'd2) begin
            e = {24'h0, model_stat()};
            m_ovr = 0; m_frm = 0; m_par = 0;
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        check("aw_latency", n, 1);
        check("wready", {31'h0, wready}, 1);
        tick();
        awvalid = 0; wvalid = 0;
        model_write(addr, data, strb);
        check("awready_one_cycle", {31'h0, awready}, 0);
        check("bvalid", {31'h0, bvalid}, 1);
        check("bresp", {30'h0, bresp}, 0);
        bready = 1; tick(); bready = 0;
        check("bvalid_done", {31'h0, bvalid}, 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
        int n;
        araddr = addr; arvalid = 1; n = 0;
        do begin tick(); n++; end while (!arready && n < 20);
        check("ar_latency", n, 1);
        tick();
        arvalid = 0;
        check("rvalid", {31'h0, rvalid}, 1);
        check("rresp", {30'h0, rresp}, 0);
        d = rdata;
        rready = 1; tick(); rready = 0;
        check("rvalid_done", {31'h0, rvalid}, 0);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr);
        logic [31:0] e, d;
        model_read(addr, e);
        axi_read(addr, d);
        check(tag, d, e);
    endtask

    task automatic push_rx(input logic [7:0] b, input logic fe, input logic pe);
        rx_data = b; rx_frame_err = fe; rx_parity_err = pe; rx_strobe = 1;
        tick();
        rx_strobe = 0; rx_frame_err = 0; rx_parity_err = 0;
        if (fe) m_frm = 1;
        if (pe) m_par = 1;
        if (rx_q.size() < 16) begin
            if (rx_q.size() == 0 && m_en) exp_irq++;
            rx_q.push_back(b);
        end else m_ovr = 1;
    endtask

    task automatic irq_check(input string tag);
        repeat (3) tick();
        check(tag, irq_count, exp_irq);
    endtask

    task automatic drain_tx();
        int guard = 0;
        while (tx_q.size() > 0 && guard < 300) begin
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                check("tx_valid", {31'h0, tx_valid}, 1);
                check("tx_data", {24'h0, tx_data}, {24'h0, tx_q[0]});
                tx_ready = 1; tick(); tx_ready = 0;
                void'(tx_q.pop_front());
                if (tx_q.size() == 0 && m_en) exp_irq++;
            end else begin
                tick();
            end
        end
        check("tx_drained", {31'h0, tx_valid}, 0);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        aresetn = 0; awaddr = 0; araddr = 0; wstrb = 0; wdata = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        rx_data = 0; rx_strobe = 0; rx_frame_err = 0; rx_parity_err = 0; tx_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'h0, awready}, 0);
        check("rst_wready", {31'h0, wready}, 0);
        check("rst_bvalid", {31'h0, bvalid}, 0);
        check("rst_arready", {31'h0, arready}, 0);
        check("rst_rvalid", {31'h0, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_tx_valid", {31'h0, tx_valid}, 0);
        check("rst_interrupt", {31'h0, interrupt}, 0);
        aresetn = 1;
        tick();

        rd_check("stat_after_reset", 4'h8);

        // Enable interrupt, single RX byte
        axi_write(4'hC, 32'h10, 4'h1);
        push_rx(8'h5A, 0, 0);
        irq_check("irq_rx_first");
        rd_check("rx_5a", 4'h0);
        rd_check("stat_en", 4'h8);
        rd_check("rx_empty_read", 4'h0);

        // Overflow RX with random bytes
        for (int i = 0; i < 17; i++) push_rx(8'($urandom_range(0, 255)), 0, 0);
        irq_check("irq_rx_fill");
        rd_check("stat_overrun", 4'h8);
        rd_check("stat_sticky_cleared", 4'h8);
        for (int i = 0; i < 16; i++) rd_check("rx_order", 4'h0);
        rd_check("rx_after_drain", 4'h0);

        // Error flags
        push_rx(8'($urandom_range(0, 255)), 1, 0);
        push_rx(8'($urandom_range(0, 255)), 0, 1);
        rd_check("stat_errs", 4'h8);
        rd_check("rx_err_byte0", 4'h0);
        rd_check("rx_err_byte1", 4'h0);

        // TX with backpressure then random drain
        tx_ready = 0;
        axi_write(4'h4, 32'($urandom_range(0, 255)), 4'h1);
        axi_write(4'h4, 32'($urandom_range(0, 255)), 4'h1);
        check("tx_valid_held", {31'h0, tx_valid}, 1);
        check("tx_head", {24'h0, tx_data}, {24'h0, tx_q[0]});
        drain_tx();
        irq_check("irq_tx_empty");

        // Ignored writes and write-only reads
        axi_write(4'h4, 32'h77, 4'b0010);
        axi_write(4'h8, 32'hFF, 4'hF);
        rd_check("stat_ignored_writes", 4'h8);
        rd_check("read_tx_reg", 4'h4);
        rd_check("read_ctrl_reg", 4'hC);

        // Fill TX past full, then flush
        for (int i = 0; i < 17; i++) axi_write(4'h4, 32'($urandom_range(0, 255)), 4'h1);
        rd_check("stat_tx_full", 4'h8);
        axi_write(4'hC, 32'h11, 4'h1);
        irq_check("irq_tx_flush");
        rd_check("stat_tx_flushed", 4'h8);

        // wvalid ahead of awvalid, bready held low
        awaddr = 4'hC; wdata = 32'h0; wstrb = 4'h1; wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("early_w_awready", {31'h0, awready}, 0);
            check("early_w_wready", {31'h0, wready}, 0);
        end
        awvalid = 1; n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        check("late_aw_latency", n, 1);
        tick();
        awvalid = 0; wvalid = 0;
        model_write(4'hC, 32'h0, 4'h1);
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", {31'h0, bvalid}, 1);
            tick();
        end
        bready = 1; tick(); bready = 0;
        check("bvalid_released", {31'h0, bvalid}, 0);
        push_rx(8'($urandom_range(0, 255)), 0, 0);
        irq_check("irq_disabled");
        rd_check("stat_disabled", 4'h8);

        // Asynchronous reset during read data phase
        push_rx(8'($urandom_range(0, 255)), 0, 0);
        axi_write(4'h4, 32'($urandom_range(0, 255)), 4'h1);
        araddr = 4'h0; arvalid = 1; n = 0;
        do begin tick(); n++; end while (!arready && n < 20);
        tick();
        arvalid = 0;
        check("pre_reset_rvalid", {31'h0, rvalid}, 1);
        #2 aresetn = 0;
        #1;
        model_reset();
        check("async_rvalid", {31'h0, rvalid}, 0);
        check("async_rdata", rdata, 0);
        check("async_tx_valid", {31'h0, tx_valid}, 0);
        tick();
        aresetn = 1;
        tick();
        rd_check("stat_post_async_reset", 4'h8);
        rd_check("rx_post_async_reset", 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
